// File: rtl/matrix_vector_mac.sv
// matrix_vector_mac: sequential 3x2 matrix-vector MAC with one shared multiplier and a valid/ready result handshake
//   clk, rst       : clock, synchronous active-high reset
//   in_valid/in_ready, A, x   : operand handshake; packed matrix (row-major, [0][0] MSB) and vector (x[0] MSB)
//   out_valid/out_ready, Y    : result handshake; packed result vector (y[0] MSB)
//   Optional macro MATRIX_VECTOR_MAC_RELU_EN clamps negative rescaled results to zero.
module matrix_vector_mac #(
    parameter int DATA_W = 4,
    parameter int ROWS   = 3,
    parameter int COLS   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ROWS*COLS*DATA_W-1:0]   A,
    input  logic [COLS*DATA_W-1:0]        x,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ROWS*DATA_W-1:0]        Y
);
    localparam int ACC_W = 2*DATA_W + $clog2(COLS);
    localparam int RW    = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int CW    = COLS > 1 ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                        state;
    logic [ROWS*COLS*DATA_W-1:0]   a_q;
    logic [COLS*DATA_W-1:0]        x_q;
    logic [RW-1:0]                 r;
    logic [CW-1:0]                 c;
    logic signed [ACC_W-1:0]       acc, acc_next;
    logic signed [DATA_W-1:0]      a_el, x_el, y_raw, y_val;
    logic signed [2*DATA_W-1:0]    prod;

    // Matrix elements are consumed in row-major order, so the captured matrix is
    // shifted left each MAC cycle and the current element is always at the top.
    // The vector is rotated so x[c] sits at the top and wraps back every row.
    assign a_el     = a_q[ROWS*COLS*DATA_W-1 -: DATA_W];
    assign x_el     = x_q[COLS*DATA_W-1 -: DATA_W];
    assign prod     = a_el * x_el;
    assign acc_next = acc + ACC_W'(prod);
    assign y_raw    = {acc_next[ACC_W-1], acc_next[DATA_W-1:1]};

`ifdef MATRIX_VECTOR_MAC_RELU_EN
    assign y_val = y_raw[DATA_W-1] ? '0 : y_raw;
`else
    assign y_val = y_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Y         <= '0;
            a_q       <= '0;
            x_q       <= '0;
            r         <= '0;
            c         <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q      <= A;
                    x_q      <= x;
                    r        <= '0;
                    c        <= '0;
                    acc      <= '0;
                    in_ready <= 1'b0;
                    state    <= MAC;
                end
                MAC: begin
                    a_q <= a_q << DATA_W;
                    x_q <= (x_q << DATA_W) | (x_q >> ((COLS-1)*DATA_W));
                    if (c == CW'(COLS-1)) begin
                        acc <= '0;
                        c   <= '0;
                        for (int i = 0; i < ROWS; i++)
                            if (r == RW'(i)) Y[(ROWS-1-i)*DATA_W +: DATA_W] <= y_val;
                        if (r == RW'(ROWS-1)) begin
                            r         <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            r <= r + RW'(1);
                        end
                    end else begin
                        acc <= acc_next;
                        c   <= c + CW'(1);
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_vector_mac.sv
// tb_matrix_vector_mac: directed scoreboard bench for matrix_vector_mac
module tb_matrix_vector_mac;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] A = '0;
    logic [7:0]  x = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] Y;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          prev_acc = 0;
    logic [11:0] sb[$];

    matrix_vector_mac dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .Y(Y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model(input logic [23:0] a, input logic [7:0] xv);
        logic [11:0]      y;
        logic signed [3:0] ae, xe;
        int               s;
        y = '0;
        for (int i = 0; i < 3; i++) begin
            s = 0;
            for (int j = 0; j < 2; j++) begin
                ae = a[(5-(i*2+j))*4 +: 4];
                xe = xv[(1-j)*4 +: 4];
                s += int'(ae) * int'(xe);
            end
            y[(2-i)*4 +: 4] = {s < 0, 3'((s >>> 1) & 7)};
`ifdef MATRIX_VECTOR_MAC_RELU_EN
            if (s < 0) y[(2-i)*4 +: 4] = 4'h0;
`endif
        end
        return y;
    endfunction

    // Offer one operand set, optionally stall the result or reset mid-MAC.
    task automatic do_op(input logic [23:0] a, input logic [7:0] xv, input int stall, input bit abort);
        int          n;
        logic [11:0] exp;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        check("in_ready_wait", 32'(n < 50), 32'd1);
        A = a;
        x = xv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        prev_acc = acc_cyc;
        acc_cyc = cyc;
        in_valid = 1'b0;
        A = ~a;
        x = ~xv;
        sb.push_back(model(a, xv));
        check("in_ready_drop", 32'(in_ready), 32'd0);
        if (abort) begin
            tick();
            tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_Y", 32'(Y), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            void'(sb.pop_back());
            return;
        end
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        check("latency", 32'(n), 32'd6);
        exp = sb.pop_front();
        check("Y", 32'(Y), 32'(exp));
        if (stall > 0) begin
            out_ready = 1'b0;
            in_valid = 1'b1;
            A = 24'h777777;
            x = 8'h77;
            for (int k = 0; k < stall; k++) begin
                tick();
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_Y", 32'(Y), 32'(exp));
                check("stall_in_ready", 32'(in_ready), 32'd0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        check("hs_out_valid", 32'(out_valid), 32'd0);
        check("hs_in_ready", 32'(in_ready), 32'd1);
        check("hs_Y_hold", 32'(Y), 32'(exp));
    endtask

    initial begin
        tick();
        tick();
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_Y", 32'(Y), 32'd0);
        rst = 1'b0;
        tick();

        do_op(24'h222222, 8'h22, 0, 1'b0);
        check("ones_Y_literal", 32'(Y), 32'h444);
        do_op(24'h222222, 8'h22, 0, 1'b0);
        check("throughput", 32'(acc_cyc - prev_acc), 32'd8);

        do_op(24'hEE0000, 8'h22, 0, 1'b0);
`ifdef MATRIX_VECTOR_MAC_RELU_EN
        check("neg_relu_Y", 32'(Y), 32'h000);
`else
        check("neg_Y", 32'(Y), 32'hC00);
`endif

        do_op(24'h007700, 8'h77, 0, 1'b0);
        check("wrap_Y", 32'(Y), 32'h010);

        do_op(24'h3A5F12, 8'h9C, 10, 1'b0);
        check("after_stall_idle", 32'(in_ready), 32'd1);

        do_op(24'h1234F5, 8'h3D, 0, 1'b1);
        do_op(24'h1234F5, 8'h3D, 0, 1'b0);

        for (int i = 0; i < 6; i++)
            do_op(24'($urandom), 8'($urandom), (i == 2) ? 3 : 0, 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
